multtable_checker: RTL and testbench

MULTTABLE_CHECKER -- requirements
Module: multtable_checker

---
 rtl/multtable_checker.sv | 139 +++++++++++++
 tb/tb_multtable_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multtable_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multtable_checker: checks a stream of (index, index*MULT) entries.  Rev 1.0
// ----------------------------------------------------------------------------
module multtable_checker #(
  parameter int MULT  = 3,
  parameter int COUNT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic [3:0] in_index,
  input  logic [7:0] in_result,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [3:0] first_err_index,
  output logic [3:0] expected_index
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [4:0] c_count = 5'(COUNT);
  localparam logic [7:0] c_mult  = 8'(MULT);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [4:0] r_count;
  logic       r_cmp_valid;
  logic [3:0] r_cmp_index;
  logic [3:0] r_cmp_exp;
  logic [7:0] r_cmp_result;
  logic [3:0] r_err_count;
  logic [3:0] r_first_err;
  logic [3:0] r_exp_index;
  logic       r_pass;
  logic       r_done;
  logic       w_ready;
  logic       w_busy;
  logic       w_arm;
  logic       w_accept;
  logic       w_mismatch;
  logic [7:0] w_product;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (r_count == c_count) w_state_next = S_DRAIN;
      S_DRAIN: w_state_next = S_DONE;
      S_DONE:  if (start) w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      S_RUN: begin
        w_busy  = 1'b1;
        w_ready = (r_count < c_count);
      end
      S_DRAIN: w_busy = 1'b1;
      default: begin
      end
    endcase
  end

  assign w_arm      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_accept   = in_valid && w_ready;
  // Indices stay below 16 and MULT below 18, so the product always fits 8 bits.
  assign w_product  = {4'd0, r_cmp_exp} * c_mult;
  assign w_mismatch = r_cmp_valid &&
                      ((r_cmp_index != r_cmp_exp) || (r_cmp_result != w_product));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count      <= 5'd0;
      r_cmp_valid  <= 1'b0;
      r_cmp_index  <= 4'd0;
      r_cmp_exp    <= 4'd0;
      r_cmp_result <= 8'd0;
      r_err_count  <= 4'd0;
      r_first_err  <= 4'd0;
      r_exp_index  <= 4'd0;
      r_pass       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // DRAIN always advances to DONE, so this marks the DONE entry edge.
      r_done <= (r_state == S_DRAIN);
      if (w_arm) begin
        r_count     <= 5'd0;
        r_cmp_valid <= 1'b0;
        r_err_count <= 4'd0;
        r_first_err <= 4'd0;
        r_exp_index <= 4'd0;
        r_pass      <= 1'b0;
      end else begin
        r_cmp_valid <= w_accept;
        if (w_accept) begin
          r_cmp_index  <= in_index;
          r_cmp_result <= in_result;
          r_cmp_exp    <= r_exp_index;
          r_exp_index  <= r_exp_index + 4'd1;
          r_count      <= r_count + 5'd1;
        end
        if (w_mismatch) begin
          if (r_err_count != 4'd15) r_err_count <= r_err_count + 4'd1;
          if (r_err_count == 4'd0) r_first_err <= r_cmp_exp;
        end
        if (r_state == S_DRAIN) r_pass <= (r_err_count == 4'd0);
      end
    end
  end

  assign in_ready        = w_ready;
  assign busy            = w_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign err_count       = r_err_count;
  assign first_err_index = r_first_err;
  assign expected_index  = r_exp_index;

endmodule
`default_nettype wire

// File: tb/tb_multtable_checker.sv
`default_nettype none
// tb_multtable_checker: randomized self-checking bench with a run-level reference model.
module tb_multtable_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, in_valid;
  logic [3:0] in_index;
  logic [7:0] in_result;

  logic       a_ready, a_busy, a_done, a_pass;
  logic [3:0] a_err, a_first, a_exp;
  logic       b_ready, b_busy, b_done, b_pass;
  logic [3:0] b_err, b_first, b_exp;

  multtable_checker #(.MULT(3), .COUNT(10)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_index(in_index), .in_result(in_result), .in_ready(a_ready),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_err_index(a_first), .expected_index(a_exp)
  );

  multtable_checker #(.MULT(17), .COUNT(16)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_index(in_index), .in_result(in_result), .in_ready(b_ready),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_err_index(b_first), .expected_index(b_exp)
  );

  bit         sel = 1'b0;
  logic       w_ready, w_busy, w_done, w_pass;
  logic [3:0] w_err, w_first, w_exp;
  assign w_ready = sel ? b_ready : a_ready;
  assign w_busy  = sel ? b_busy  : a_busy;
  assign w_done  = sel ? b_done  : a_done;
  assign w_pass  = sel ? b_pass  : a_pass;
  assign w_err   = sel ? b_err   : a_err;
  assign w_first = sel ? b_first : a_first;
  assign w_exp   = sel ? b_exp   : a_exp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] q_idx[$];
  logic [7:0] q_res[$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int cur_mult();
    return sel ? 17 : 3;
  endfunction

  function automatic int cur_cnt();
    return sel ? 16 : 10;
  endfunction

  // mode 0 clean, 1 bad result at entry 4, 2 index 5 skipped, 3 every result off by one
  task automatic build(input int mode, input int corrupt_pct);
    q_idx.delete();
    q_res.delete();
    for (int i = 0; i < cur_cnt(); i++) begin
      int ix;
      int rs;
      ix = (mode == 2 && i >= 5) ? i + 1 : i;
      rs = (ix * cur_mult()) % 256;
      if (mode == 1 && i == 4) rs = 13;
      if (mode == 3) rs = (rs + 1) % 256;
      if (corrupt_pct > 0 && $urandom_range(99) < corrupt_pct) begin
        if ($urandom_range(1) == 0) ix = $urandom_range(15);
        else rs = $urandom_range(255);
      end
      q_idx.push_back(4'(ix));
      q_res.push_back(8'(rs));
    end
  endtask

  // Run-level expectation: the k-th accepted entry must be (k, k*MULT mod 256).
  task automatic model(output int e, output int f, output int p);
    int errs;
    errs = 0;
    f = 0;
    for (int i = 0; i < q_idx.size(); i++) begin
      if (int'(q_idx[i]) != (i % 16) || int'(q_res[i]) != ((i * cur_mult()) % 256)) begin
        if (errs == 0) f = i % 16;
        errs++;
      end
    end
    e = (errs > 15) ? 15 : errs;
    p = (errs == 0) ? 1 : 0;
  endtask

  task automatic check_zero();
    chk("rst_in_ready", w_ready, 0);
    chk("rst_busy", w_busy, 0);
    chk("rst_done", w_done, 0);
    chk("rst_pass", w_pass, 0);
    chk("rst_err_count", w_err, 0);
    chk("rst_first_err_index", w_first, 0);
    chk("rst_expected_index", w_exp, 0);
  endtask

  task automatic arm();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", w_busy, 1);
    chk("err_cleared", w_err, 0);
    chk("exp_index_cleared", w_exp, 0);
    chk("pass_cleared", w_pass, 0);
  endtask

  task automatic drive(input int gap_pct, input bit hold_valid, input int stop_after,
                       input bit timed);
    int n, k, c0, cd, e, f, p;
    n  = cur_cnt();
    k  = 0;
    c0 = -1;
    cd = -1;
    for (int budget = 0; budget < 600 && cd < 0; budget++) begin
      @(negedge clk);
      if (stop_after > 0 && k >= stop_after) break;
      if (w_done) begin
        cd = cyc;
      end else if (k == n) begin
        in_valid = hold_valid;
        chk("ready_low_after_last", w_ready, 0);
      end else begin
        in_valid  = ($urandom_range(99) >= gap_pct);
        in_index  = q_idx[k];
        in_result = q_res[k];
        if (in_valid && w_ready) begin
          if (c0 < 0) c0 = cyc;
          k++;
        end
      end
    end
    if (stop_after > 0) return;
    in_valid = 1'b0;
    if (cd < 0) begin
      chk("done_timeout", 0, 1);
      return;
    end
    model(e, f, p);
    chk("accepted_before_done", k, n);
    if (timed) chk("done_latency", cd - c0, n + 2);
    chk("err_count", w_err, e);
    chk("first_err_index", w_first, f);
    chk("pass", w_pass, p);
    chk("expected_index", w_exp, n % 16);
    chk("busy_in_done", w_busy, 0);
    @(negedge clk);
    chk("done_one_cycle", w_done, 0);
    chk("pass_held", w_pass, p);
  endtask

  initial begin
    int seen;
    reset     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_index  = 4'd0;
    in_result = 8'd0;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    check_zero();
    sel = 1'b1;
    check_zero();
    sel = 1'b0;
    reset = 1'b1;

    build(0, 0); arm(); drive(0, 1'b0, 0, 1'b1);
    build(1, 0); arm(); drive(0, 1'b0, 0, 1'b1);
    build(2, 0); arm(); drive(0, 1'b0, 0, 1'b1);
    build(0, 0); arm(); drive(40, 1'b1, 0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      build(0, 25);
      arm();
      drive($urandom_range(50), 1'(($urandom_range(1))), 0, 1'b0);
    end

    // Abort after five entries with start and in_valid fighting the reset.
    build(0, 0); arm(); drive(0, 1'b0, 5, 1'b0);
    start    = 1'b1;
    in_valid = 1'b1;
    reset    = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    check_zero();
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (w_done) seen = 1;
    end
    chk("no_done_after_abort", seen, 0);
    build(0, 0); arm(); drive(0, 1'b0, 0, 1'b1);

    sel = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    build(3, 0); arm(); drive(0, 1'b0, 0, 1'b1);
    build(0, 0); arm(); drive(20, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
